// File: rtl/vexriscv_bus_pkg.sv
// Shared types and helpers for the VexRiscv data-bus to RAM controller.
// Holds the access-size encoding, the response record and the byte-enable builder.
package vexriscv_bus_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } rsp_t;

  // Byte lanes touched by an access of the given size at the given low address bits.
  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/vexriscv_rsp_fifo.sv
// Synchronous response FIFO with fall-through from an empty state, so a read
// response can reach the CPU in the same cycle the RAM produces it.
module vexriscv_rsp_fifo
  import vexriscv_bus_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  rsp_t                     push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output rsp_t                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rsp_t            mem_r [DEPTH];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;
  logic            empty_s;
  logic            store_s;
  logic            drain_s;

  assign empty_s = (count_r == {CW{1'b0}});
  // A push that is consumed immediately while empty never occupies storage.
  assign store_s = push & ~(empty_s & pop);
  assign drain_s = pop & ~empty_s;
  assign count   = count_r;

  // Head selection: stored entry first, otherwise the bypassed push, otherwise zero.
  always_comb begin
    head       = '0;
    head_valid = 1'b0;
    if (!empty_s) begin
      head       = mem_r[rd_ptr_r];
      head_valid = 1'b1;
    end else if (push) begin
      head       = push_data;
      head_valid = 1'b1;
    end else begin
      head       = '0;
      head_valid = 1'b0;
    end
  end

  // Storage array; contents are only meaningful where count says so.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; reset discards anything queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (drain_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + {{(CW-1){1'b0}}, store_s} - {{(CW-1){1'b0}}, drain_s};
    end
  end

endmodule

// File: rtl/vexriscv_dbus_ram_ctrl.sv
// VexRiscv dbus initiator into the shared byte-write RAM: range/alignment decode,
// lane steering, one-cycle read tracking and credit-based response buffering.
module vexriscv_dbus_ram_ctrl
  import vexriscv_bus_pkg::*;
#(
  parameter int          RAM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RSP_DEPTH = 2,
  localparam int         AW        = $clog2(RAM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [31:0]   cmd_addr,
  input  logic [31:0]   cmd_data,
  input  logic [1:0]    cmd_size,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic          rsp_error,
  output logic          ram_en,
  output logic [3:0]    ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_din,
  input  logic [31:0]   ram_dout
);

  localparam int             CW          = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW:0]    RSP_DEPTH_C = RSP_DEPTH[CW:0];

  logic          ready_en_r;
  logic          inflight_r;
  logic          rd_err_r;
  logic          in_range_s;
  logic          align_ok_s;
  logic          legal_s;
  logic          accept_s;
  logic          rd_accept_s;
  logic [CW-1:0] count_s;
  logic [CW:0]   used_s;
  rsp_t          push_data_s;
  rsp_t          head_s;

  // The window is aligned to its own size, so a tag compare on the upper bits decodes it.
  assign in_range_s = (cmd_addr[31:AW+2] == BASE_ADDR[31:AW+2]);

  // Alignment and size legality; size 3 falls into the default.
  always_comb begin
    align_ok_s = 1'b0;
    case (cmd_size)
      SZ_BYTE: align_ok_s = 1'b1;
      SZ_HALF: align_ok_s = ~cmd_addr[0];
      SZ_WORD: align_ok_s = (cmd_addr[1:0] == 2'b00);
      default: align_ok_s = 1'b0;
    endcase
  end

  assign legal_s     = in_range_s & align_ok_s;
  assign accept_s    = cmd_valid & cmd_ready;
  assign rd_accept_s = accept_s & ~cmd_wr;
  assign ram_en      = accept_s & legal_s;

  // Lane steering toward the RAM; everything idles at zero when no access is issued.
  always_comb begin
    ram_addr = {AW{1'b0}};
    ram_we   = 4'b0000;
    ram_din  = 32'h0000_0000;
    if (ram_en) begin
      ram_addr = cmd_addr[AW+1:2];
      if (cmd_wr) begin
        ram_we = be_from_size(cmd_size, cmd_addr[1:0]);
        case (cmd_size)
          SZ_BYTE: ram_din = {4{cmd_data[7:0]}};
          SZ_HALF: ram_din = {2{cmd_data[15:0]}};
          SZ_WORD: ram_din = cmd_data;
          default: ram_din = 32'h0000_0000;
        endcase
      end else begin
        ram_we  = 4'b0000;
        ram_din = 32'h0000_0000;
      end
    end else begin
      ram_addr = {AW{1'b0}};
      ram_we   = 4'b0000;
      ram_din  = 32'h0000_0000;
    end
  end

  // Read tracking: a read accepted this cycle produces exactly one response next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_r <= 1'b0;
      inflight_r <= 1'b0;
      rd_err_r   <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
      inflight_r <= rd_accept_s;
      rd_err_r   <= rd_accept_s & ~legal_s;
    end
  end

  // Response record for the read resolved this cycle.
  always_comb begin
    push_data_s = '0;
    if (rd_err_r) begin
      push_data_s.data  = 32'h0000_0000;
      push_data_s.error = 1'b1;
    end else begin
      push_data_s.data  = ram_dout;
      push_data_s.error = 1'b0;
    end
  end

  // Credits use the registered occupancy only, keeping rsp_ready off the cmd_ready path.
  assign used_s    = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
  assign cmd_ready = ready_en_r & (used_s < RSP_DEPTH_C);

  vexriscv_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight_r),
    .push_data  (push_data_s),
    .pop        (rsp_valid & rsp_ready),
    .head_valid (rsp_valid),
    .head       (head_s),
    .count      (count_s)
  );

  assign rsp_data  = head_s.data;
  assign rsp_error = head_s.error;

endmodule
